// File: rtl/kf8259_common_pkg.sv
// Shared KF8259 types, OCW2 command codes and one-hot helpers.
package kf8259_common_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK1  = 2'd1,
        ST_WAIT2 = 2'd2,
        ST_ACK2  = 2'd3
    } ack_state_t;

    // OCW2 {R, SL, EOI} command codes
    localparam logic [2:0] NSEOI        = 3'b001;
    localparam logic [2:0] SEOI         = 3'b011;
    localparam logic [2:0] ROT_NSEOI    = 3'b101;
    localparam logic [2:0] ROT_SEOI     = 3'b111;
    localparam logic [2:0] SET_PRI      = 3'b110;
    localparam logic [2:0] SET_ROT_AEOI = 3'b100;
    localparam logic [2:0] CLR_ROT_AEOI = 3'b000;
    localparam logic [2:0] NOP          = 3'b010;

    localparam logic [2:0] PRIORITY_ROTATE_RESET = 3'b111;

    function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
        logic [2:0] index;
        index = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) index = 3'(i);
        end
        return index;
    endfunction

    function automatic logic [7:0] index_to_onehot(input logic [2:0] index);
        return 8'b0000_0001 << index;
    endfunction

endpackage

// File: rtl/kf8259_inta_edge_detect.sv
// INTA# edge detector: one-cycle delayed copy plus fall/rise strobes.
module kf8259_inta_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic interrupt_acknowledge_n,
    output logic inta_fall_c,
    output logic inta_rise_c
);

    logic inta_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) inta_q <= 1'b1;
        else       inta_q <= interrupt_acknowledge_n;
    end

    assign inta_fall_c = inta_q & ~interrupt_acknowledge_n;
    assign inta_rise_c = ~inta_q & interrupt_acknowledge_n;

endmodule

// File: rtl/kf8259_ack_sequencer.sv
// INTA two-pulse sequencer, OCW2 EOI/rotate decode and priority-rotation owner.
// Define KF8259_AEOI_ROTATE_EN to enable rotate-on-AEOI (OCW2 codes 100/000).
module kf8259_ack_sequencer
    import kf8259_common_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       init_strobe,
    input  logic       interrupt_acknowledge_n,
    input  logic [7:0] winning_request,
    input  logic [7:0] highest_level_in_service,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi_config,
    input  logic       write_ocw2,
    input  logic [7:0] ocw2_data,
    output logic       latch_in_service,
    output logic [7:0] acknowledged_interrupt,
    output logic [7:0] end_of_interrupt,
    output logic [2:0] priority_rotate,
    output logic [7:0] clear_request,
    output logic [7:0] vector_out,
    output logic       vector_out_enable,
    output logic       ack_busy
);

    logic       inta_fall_c;
    logic       inta_rise_c;
    ack_state_t state;
    logic       spurious;
    logic       rotate_on_aeoi;
    logic [7:0] ocw_eoi_c;
    logic       ocw_rotate_c;
    logic [2:0] ocw_rotate_level_c;
    logic       aeoi_fire_c;
    logic [2:0] ocw2_level;
    logic [1:0] ocw2_unused;

    kf8259_inta_edge_detect u_inta_edge_detect (
        .clock                   (clock),
        .reset                   (reset),
        .interrupt_acknowledge_n (interrupt_acknowledge_n),
        .inta_fall_c             (inta_fall_c),
        .inta_rise_c             (inta_rise_c)
    );

    assign ocw2_level  = ocw2_data[2:0];
    assign ocw2_unused = ocw2_data[4:3];

    // OCW2 EOI mask and rotation request for the current write
    always_comb begin
        ocw_eoi_c          = 8'h00;
        ocw_rotate_c       = 1'b0;
        ocw_rotate_level_c = 3'd0;
        if (write_ocw2) begin
            case (ocw2_data[7:5])
                NSEOI: ocw_eoi_c = highest_level_in_service;
                SEOI:  ocw_eoi_c = index_to_onehot(ocw2_level);
                ROT_NSEOI: begin
                    ocw_eoi_c          = highest_level_in_service;
                    ocw_rotate_c       = |highest_level_in_service;
                    ocw_rotate_level_c = onehot_to_index(highest_level_in_service);
                end
                ROT_SEOI: begin
                    ocw_eoi_c          = index_to_onehot(ocw2_level);
                    ocw_rotate_c       = 1'b1;
                    ocw_rotate_level_c = ocw2_level;
                end
                SET_PRI: begin
                    ocw_rotate_c       = 1'b1;
                    ocw_rotate_level_c = ocw2_level;
                end
                default: ocw_eoi_c = 8'h00;
            endcase
        end
    end

    assign aeoi_fire_c = (state == ST_ACK2) & inta_rise_c & auto_eoi_config & ~spurious;

`ifndef KF8259_AEOI_ROTATE_EN
    assign rotate_on_aeoi = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                  <= ST_IDLE;
            spurious               <= 1'b0;
            latch_in_service       <= 1'b0;
            acknowledged_interrupt <= 8'h00;
            end_of_interrupt       <= 8'h00;
            priority_rotate        <= PRIORITY_ROTATE_RESET;
            clear_request          <= 8'h00;
            vector_out             <= 8'h00;
            vector_out_enable      <= 1'b0;
            ack_busy               <= 1'b0;
`ifdef KF8259_AEOI_ROTATE_EN
            rotate_on_aeoi         <= 1'b0;
`endif
        end else if (init_strobe) begin
            state                  <= ST_IDLE;
            spurious               <= 1'b0;
            latch_in_service       <= 1'b0;
            acknowledged_interrupt <= 8'h00;
            end_of_interrupt       <= 8'h00;
            priority_rotate        <= PRIORITY_ROTATE_RESET;
            clear_request          <= 8'h00;
            vector_out             <= 8'h00;
            vector_out_enable      <= 1'b0;
            ack_busy               <= 1'b0;
`ifdef KF8259_AEOI_ROTATE_EN
            rotate_on_aeoi         <= 1'b0;
`endif
        end else begin
            latch_in_service <= 1'b0;
            clear_request    <= 8'h00;
            end_of_interrupt <= ocw_eoi_c | (aeoi_fire_c ? acknowledged_interrupt : 8'h00);

            // OCW2 rotation takes precedence over a same-cycle AEOI rotation
            if (ocw_rotate_c)
                priority_rotate <= ocw_rotate_level_c;
            else if (aeoi_fire_c && rotate_on_aeoi)
                priority_rotate <= onehot_to_index(acknowledged_interrupt);

`ifdef KF8259_AEOI_ROTATE_EN
            if (write_ocw2 && (ocw2_data[7:5] == SET_ROT_AEOI))
                rotate_on_aeoi <= 1'b1;
            else if (write_ocw2 && (ocw2_data[7:5] == CLR_ROT_AEOI))
                rotate_on_aeoi <= 1'b0;
`endif

            case (state)
                ST_IDLE: begin
                    if (inta_fall_c) begin
                        // No winner means a spurious acknowledge, reported as IR7
                        acknowledged_interrupt <= (|winning_request) ? winning_request : 8'h80;
                        spurious               <= ~|winning_request;
                        latch_in_service       <= |winning_request;
                        clear_request          <= winning_request;
                        state                  <= ST_ACK1;
                        ack_busy               <= 1'b1;
                    end
                end
                ST_ACK1: begin
                    if (inta_rise_c) state <= ST_WAIT2;
                end
                ST_WAIT2: begin
                    if (inta_fall_c) begin
                        state             <= ST_ACK2;
                        vector_out_enable <= 1'b1;
                        vector_out        <= {vector_base, onehot_to_index(acknowledged_interrupt)};
                    end
                end
                ST_ACK2: begin
                    if (inta_rise_c) begin
                        state                  <= ST_IDLE;
                        ack_busy               <= 1'b0;
                        vector_out_enable      <= 1'b0;
                        vector_out             <= 8'h00;
                        acknowledged_interrupt <= 8'h00;
                        spurious               <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ack_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kf8259_ack_sequencer.sv
// Scoreboard bench for kf8259_ack_sequencer: directed scenarios followed by random traffic.
module tb_kf8259_ack_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       init_strobe;
    logic       interrupt_acknowledge_n;
    logic [7:0] winning_request;
    logic [7:0] highest_level_in_service;
    logic [4:0] vector_base;
    logic       auto_eoi_config;
    logic       write_ocw2;
    logic [7:0] ocw2_data;
    logic       latch_in_service;
    logic [7:0] acknowledged_interrupt;
    logic [7:0] end_of_interrupt;
    logic [2:0] priority_rotate;
    logic [7:0] clear_request;
    logic [7:0] vector_out;
    logic       vector_out_enable;
    logic       ack_busy;

    kf8259_ack_sequencer dut (
        .clock                    (clock),
        .reset                    (reset),
        .init_strobe              (init_strobe),
        .interrupt_acknowledge_n  (interrupt_acknowledge_n),
        .winning_request          (winning_request),
        .highest_level_in_service (highest_level_in_service),
        .vector_base              (vector_base),
        .auto_eoi_config          (auto_eoi_config),
        .write_ocw2               (write_ocw2),
        .ocw2_data                (ocw2_data),
        .latch_in_service         (latch_in_service),
        .acknowledged_interrupt   (acknowledged_interrupt),
        .end_of_interrupt         (end_of_interrupt),
        .priority_rotate          (priority_rotate),
        .clear_request            (clear_request),
        .vector_out               (vector_out),
        .vector_out_enable        (vector_out_enable),
        .ack_busy                 (ack_busy)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Expected observable events, in order of appearance
    logic [7:0] latch_q[$];
    logic [7:0] eoi_q[$];
    logic [7:0] vec_q[$];
    int         rot_q[$];

    // Reference model state
    int m_pri      = 7;
    bit m_rot_aeoi = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // OCW2 semantics read field by field: R rotates, SL selects level L, EOI clears
    task automatic model_ocw(input logic [7:0] cmd, input logic [7:0] isr,
                             inout logic [7:0] mask, inout int pri);
        bit         r, sl, e;
        int         l;
        logic [7:0] one;
        r   = cmd[7];
        sl  = cmd[6];
        e   = cmd[5];
        l   = int'(cmd[2:0]);
        one = 8'h01 << l;
        if (e) begin
            mask |= sl ? one : isr;
            if (r) begin
                if (sl) pri = l;
                else if (isr != 8'h00) pri = $clog2(isr);
            end
        end else if (r && sl) pri = l;
`ifdef KF8259_AEOI_ROTATE_EN
        else if (r && !sl) m_rot_aeoi = 1'b1;
        else if (!r && !sl) m_rot_aeoi = 1'b0;
`endif
    endtask

    task automatic expect_update(input logic [7:0] mask, input int newpri);
        if (mask != 8'h00) eoi_q.push_back(mask);
        if (newpri != m_pri) rot_q.push_back(newpri);
        m_pri = newpri;
    endtask

    function automatic logic [7:0] rand_onehot_or_zero();
        logic [7:0] v;
        v = 8'h01 << $urandom_range(0, 7);
        return ($urandom_range(0, 4) == 0) ? 8'h00 : v;
    endfunction

    // Full two-pulse INTA cycle, optionally with an OCW2 write on the second rise
    task automatic do_inta(input logic [7:0] win, input logic [4:0] base, input bit aeoi,
                           input bit ocw_en, input logic [7:0] ocw, input logic [7:0] isr);
        logic [7:0] ack, mask;
        bit         spur;
        int         newpri;
        @(negedge clock);
        winning_request         = win;
        vector_base             = base;
        auto_eoi_config         = aeoi;
        interrupt_acknowledge_n = 1'b0;
        spur = (win == 8'h00);
        ack  = spur ? 8'h80 : win;
        if (!spur) latch_q.push_back(win);
        @(negedge clock);
        check("latch_timing", 32'(latch_in_service), 32'(!spur));
        check("busy_in_ack", 32'(ack_busy), 32'd1);
        winning_request = 8'(   $urandom);
        repeat ($urandom_range(0, 2)) @(negedge clock);
        interrupt_acknowledge_n = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        interrupt_acknowledge_n = 1'b0;
        vec_q.push_back({base, 3'($clog2(ack))});
        @(negedge clock);
        check("vector_enable_timing", 32'(vector_out_enable), 32'd1);
        repeat ($urandom_range(0, 2)) @(negedge clock);
        interrupt_acknowledge_n = 1'b1;
        mask   = 8'h00;
        newpri = m_pri;
        if (aeoi && !spur) begin
            mask = ack;
            if (m_rot_aeoi) newpri = $clog2(ack);
        end
        if (ocw_en) begin
            write_ocw2               = 1'b1;
            ocw2_data                = ocw;
            highest_level_in_service = isr;
            model_ocw(ocw, isr, mask, newpri);
        end
        expect_update(mask, newpri);
        @(negedge clock);
        write_ocw2 = 1'b0;
        check("eoi_after_second_rise", 32'(end_of_interrupt), 32'(mask));
        check("vector_drop", 32'(vector_out_enable), 32'd0);
        check("busy_idle", 32'(ack_busy), 32'd0);
        check("priority_after_ack", 32'(priority_rotate), 32'(m_pri));
    endtask

    task automatic do_ocw(input logic [7:0] cmd, input logic [7:0] isr);
        logic [7:0] mask;
        int         newpri;
        @(negedge clock);
        write_ocw2               = 1'b1;
        ocw2_data                = cmd;
        highest_level_in_service = isr;
        mask   = 8'h00;
        newpri = m_pri;
        model_ocw(cmd, isr, mask, newpri);
        expect_update(mask, newpri);
        @(negedge clock);
        write_ocw2 = 1'b0;
        check("ocw_eoi", 32'(end_of_interrupt), 32'(mask));
        check("ocw_priority", 32'(priority_rotate), 32'(m_pri));
    endtask

    task automatic do_init(input bit ocw_en, input logic [7:0] cmd);
        @(negedge clock);
        init_strobe              = 1'b1;
        write_ocw2               = ocw_en;
        ocw2_data                = cmd;
        highest_level_in_service = 8'hFF;
        if (m_pri != 7) rot_q.push_back(7);
        m_pri      = 7;
        m_rot_aeoi = 1'b0;
        @(negedge clock);
        init_strobe = 1'b0;
        write_ocw2  = 1'b0;
        check("init_eoi", 32'(end_of_interrupt), 32'd0);
        check("init_priority", 32'(priority_rotate), 32'd7);
        check("init_busy", 32'(ack_busy), 32'd0);
    endtask

    // Async reset after the first pulse (WAIT2) or during the second (ACK2)
    task automatic reset_mid(input bit in_ack2, input logic [4:0] base);
        @(negedge clock);
        winning_request         = 8'h04;
        vector_base             = base;
        auto_eoi_config         = 1'b1;
        interrupt_acknowledge_n = 1'b0;
        latch_q.push_back(8'h04);
        @(negedge clock);
        interrupt_acknowledge_n = 1'b1;
        @(negedge clock);
        if (in_ack2) begin
            interrupt_acknowledge_n = 1'b0;
            vec_q.push_back({base, 3'd2});
            @(negedge clock);
            check("vector_before_reset", 32'(vector_out_enable), 32'd1);
        end
        #2 reset = 1'b1;
        #1;
        check("reset_vector_enable", 32'(vector_out_enable), 32'd0);
        check("reset_busy", 32'(ack_busy), 32'd0);
        check("reset_ack_level", 32'(acknowledged_interrupt), 32'd0);
        check("reset_priority", 32'(priority_rotate), 32'd7);
        m_pri      = 7;
        m_rot_aeoi = 1'b0;
        interrupt_acknowledge_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_eoi", 32'(end_of_interrupt), 32'd0);
        check("post_reset_busy", 32'(ack_busy), 32'd0);
    endtask

    // Monitor: every pulse or change the DUT presents must match the next expected event
    logic       prev_ve;
    logic [2:0] prev_pr;
    always @(negedge clock) begin
        if (reset) begin
            prev_ve = vector_out_enable;
            prev_pr = priority_rotate;
        end else begin
            if (latch_in_service) begin
                if (latch_q.size() == 0) check("latch_unexpected", 32'(latch_in_service), 32'd0);
                else begin
                    logic [7:0] e;
                    e = latch_q.pop_front();
                    check("clear_request", 32'(clear_request), 32'(e));
                    check("acknowledged_interrupt", 32'(acknowledged_interrupt), 32'(e));
                end
            end else if (clear_request != 8'h00) begin
                check("clear_without_latch", 32'(clear_request), 32'd0);
            end
            if (end_of_interrupt != 8'h00) begin
                if (eoi_q.size() == 0) check("eoi_unexpected", 32'(end_of_interrupt), 32'd0);
                else check("eoi_mask", 32'(end_of_interrupt), 32'(eoi_q.pop_front()));
            end
            if (vector_out_enable && !prev_ve) begin
                if (vec_q.size() == 0) check("vector_unexpected", 32'(vector_out_enable), 32'd0);
                else check("vector_out", 32'(vector_out), 32'(vec_q.pop_front()));
            end
            if (priority_rotate != prev_pr) begin
                if (rot_q.size() == 0) check("rotate_unexpected", 32'(priority_rotate), 32'(prev_pr));
                else check("priority_rotate", 32'(priority_rotate), 32'(rot_q.pop_front()));
            end
            prev_ve = vector_out_enable;
            prev_pr = priority_rotate;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset                    = 1'b1;
        init_strobe              = 1'b0;
        interrupt_acknowledge_n  = 1'b1;
        winning_request          = 8'h00;
        highest_level_in_service = 8'h00;
        vector_base              = 5'h00;
        auto_eoi_config          = 1'b0;
        write_ocw2               = 1'b0;
        ocw2_data                = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_latch", 32'(latch_in_service), 32'd0);
        check("rst_ack", 32'(acknowledged_interrupt), 32'd0);
        check("rst_eoi", 32'(end_of_interrupt), 32'd0);
        check("rst_priority", 32'(priority_rotate), 32'd7);
        check("rst_clear", 32'(clear_request), 32'd0);
        check("rst_vector", 32'(vector_out), 32'd0);
        check("rst_vector_enable", 32'(vector_out_enable), 32'd0);
        check("rst_busy", 32'(ack_busy), 32'd0);
        reset = 1'b0;

        do_inta(8'h08, 5'h01, 1'b0, 1'b0, 8'h00, 8'h00);
        do_ocw(8'h80, 8'h00);
        do_inta(8'h08, 5'h01, 1'b1, 1'b0, 8'h00, 8'h00);
        do_inta(8'h00, 5'h1A, 1'b1, 1'b0, 8'h00, 8'h00);
        do_ocw(8'hE5, 8'h40);
        do_ocw(8'h20, 8'h02);
        do_inta(8'h10, 5'h05, 1'b1, 1'b1, 8'h61, 8'h01);
        reset_mid(1'b0, 5'h11);
        do_ocw(8'hC2, 8'h00);
        do_init(1'b0, 8'h00);
        reset_mid(1'b1, 5'h0C);
        do_ocw(8'hC4, 8'h00);
        do_init(1'b1, 8'hE3);

        for (int n = 0; n < 80; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 5)
                do_inta(rand_onehot_or_zero(), 5'($urandom), 1'($urandom), 1'($urandom),
                        8'($urandom), rand_onehot_or_zero());
            else if (kind <= 8)
                do_ocw(8'($urandom), rand_onehot_or_zero());
            else
                do_init(1'($urandom), 8'($urandom));
        end

        repeat (3) @(negedge clock);
        check("latch_queue_drained", 32'(latch_q.size()), 32'd0);
        check("eoi_queue_drained", 32'(eoi_q.size()), 32'd0);
        check("vector_queue_drained", 32'(vec_q.size()), 32'd0);
        check("rotate_queue_drained", 32'(rot_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/kf8259_ack_sequencer.md
# kf8259_ack_sequencer

Interrupt-acknowledge and end-of-interrupt sequencer for the KF8259 core. It tracks the two-pulse 8086 INTA cycle and pulses the in-service latch on the first pulse. It drives the vector on the second pulse, decodes OCW2 EOI and rotate commands, and owns the priority-rotation register shared by the priority resolver and the in-service block.

## Interface
Parameters: none.
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- init_strobe  in  1  one-cycle ICW1 write; synchronous re-initialise
- interrupt_acknowledge_n  in  1  INTA#, already synchronised to clock
- winning_request  in  8  one-hot highest unmasked pending request from the resolver (0 = none)
- highest_level_in_service  in  8  one-hot highest in-service level
- vector_base  in  5  ICW2 bits T7..T3
- auto_eoi_config  in  1  ICW4 AEOI bit
- write_ocw2  in  1  one-cycle OCW2 write strobe
- ocw2_data  in  8  OCW2 byte; bits 7:5 = R,SL,EOI; bits 2:0 = L
- latch_in_service  out  1  one-cycle pulse to the in-service block
- acknowledged_interrupt  out  8  one-hot level being latched or acknowledged
- end_of_interrupt  out  8  one-cycle one-hot clear mask to the in-service block
- priority_rotate  out  3  lowest-priority level index
- clear_request  out  8  one-cycle pulse clearing the edge latch of the acknowledged IR
- vector_out  out  8  interrupt vector
- vector_out_enable  out  1  vector valid (bus drive enable)
- ack_busy  out  1  high in every state except IDLE

## Operation
- Edge detection: inta_q is inta_n delayed one cycle. A fall is inta_q=1 and inta_n=0. A rise is inta_q=0 and inta_n=1. Reset value of inta_q is 1.
- FSM states: IDLE, ACK1, WAIT2, ACK2.
- IDLE, on fall:
  - Capture ack_level = winning_request.
  - If winning_request is nonzero: pulse latch_in_service and clear_request = winning_request.
  - If winning_request is zero (spurious): ack_level = 8'h80, set the spurious flag, no latch or clear pulse.
  - Go to ACK1.
- ACK1, on rise: go to WAIT2.
- WAIT2, on fall: go to ACK2 and assert vector_out_enable with vector_out = {vector_base, index(ack_level)}.
- ACK2, on rise: deassert vector_out_enable and go to IDLE.
  - If auto_eoi_config=1 and not spurious: pulse end_of_interrupt = ack_level.
  - If rotate_on_aeoi is also set: priority_rotate = index(ack_level).
- acknowledged_interrupt = ack_level, held from the ACK1 entry until IDLE.
- OCW2 decode of R,SL,EOI, on write_ocw2:
  - 001 non-specific EOI: EOI = highest_level_in_service.
  - 011 specific EOI: EOI = onehot(L).
  - 101 rotate on non-specific EOI: EOI = highest_level_in_service; if that is nonzero, priority_rotate = its index.
  - 111 rotate on specific EOI: EOI = onehot(L), priority_rotate = L.
  - 110 set priority: priority_rotate = L.
  - 100 sets rotate_on_aeoi; 000 clears rotate_on_aeoi.
  - 010 is a no-op.
- Simultaneous OCW2 EOI and AEOI in the same cycle: end_of_interrupt is the OR of both masks. The OCW2 value wins for priority_rotate.
- init_strobe: FSM to IDLE, priority_rotate = 3'b111, rotate_on_aeoi = 0, all pulses and vector_out_enable cleared in the next cycle. init_strobe overrides a same-cycle OCW2 write.
- A fall seen in ACK1 or ACK2, or a rise seen in IDLE or WAIT2, is ignored.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, except priority_rotate = 3'b111. FSM resets to IDLE; rotate_on_aeoi to 0.
- latch_in_service and clear_request assert exactly one cycle, in the cycle after the clock edge at which inta_n is first sampled 0 in IDLE.
- vector_out_enable rises one cycle after the second fall is sampled and falls one cycle after the second rise is sampled.
- end_of_interrupt from OCW2 is a single-cycle pulse one cycle after write_ocw2. The AEOI pulse comes one cycle after the second rise.
- priority_rotate updates on the same edge as the corresponding end_of_interrupt pulse.
- Asynchronous reset mid-sequence aborts immediately: no EOI pulse is issued and the vector drive drops.

## Configuration
- KF8259_AEOI_ROTATE_EN defined: OCW2 codes 100 and 000 control rotate_on_aeoi, and AEOI rotates priority.
- Not defined: 100 and 000 are no-ops, rotate_on_aeoi is tied 0, and AEOI never changes priority_rotate.

## Structure
- Shared package kf8259_common_pkg holds:
  - the FSM state enum;
  - OCW2 command constants (NSEOI, SEOI, ROT_NSEOI, ROT_SEOI, SET_PRI, SET_ROT_AEOI, CLR_ROT_AEOI, NOP);
  - onehot_to_index and index_to_onehot functions;
  - the PRIORITY_ROTATE_RESET = 3'b111 constant.
- One sub-module, kf8259_inta_edge_detect: the inta_q register plus the fall and rise outputs.

## Test plan
- Winning_request=8'h08, vector_base=5'h01, two INTA pulses: latch_in_service and clear_request=8'h08 pulse once after the first fall; vector_out=8'h0B during the second pulse.
- Same as above with auto_eoi_config=1 and OCW2 100 written first: end_of_interrupt=8'h08 one cycle after the second rise; priority_rotate=3.
- Winning_request=0 at the first fall: no latch pulse; vector_out={vector_base,3'd7}; no AEOI pulse even with auto_eoi_config=1.
- OCW2 0xE5 (rotate on specific EOI, L=5): end_of_interrupt=8'h20 and priority_rotate=5 one cycle later. Then OCW2 0x20 with highest_level_in_service=8'h02: end_of_interrupt=8'h02 only.
- OCW2 0x61 (SEOI L=1) in the same cycle as an AEOI of level 4: end_of_interrupt=8'h12.
- Assert reset in WAIT2, then init_strobe after an OCW2 0xC2: FSM returns to IDLE, vector_out_enable=0, priority_rotate=3'b111.
